rad2_divider_seq: RTL and testbench

RAD2_DIVIDER_SEQ -- requirements
Module: rad2_divider_seq

---
 rtl/rad2_div_pkg.sv | 19 +
 rtl/rad2_div_step.sv | 20 ++
 rtl/rad2_divider_seq.sv | 161 ++++++++++++++++
 tb/tb_rad2_divider_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rad2_div_pkg.sv
// rtl/rad2_div_pkg.sv - shared widths and state encoding for the radix-2 divider
package rad2_div_pkg;

    localparam int X_W     = 32;
    localparam int Y_W     = 11;
    localparam int FRAC    = 10;
    localparam int DVD_W   = X_W + FRAC;
    localparam int REM_W   = Y_W + 1;
    localparam int CNT_W   = 6;
    localparam int N_STEPS = DVD_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rad2_div_step.sv
// rtl/rad2_div_step.sv - one restoring trial-subtract step of the radix-2 divider
module rad2_div_step
    import rad2_div_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [Y_W-1:0]   dvs,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    logic [REM_W:0] shifted;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {2'b00, dvs});
        rem_out = q_bit ? REM_W'(shifted - {2'b00, dvs}) : shifted[REM_W-1:0];
    end

endmodule

// File: rtl/rad2_divider_seq.sv
// rtl/rad2_divider_seq.sv - sequential signed divider, q = trunc((x << FRAC) / y), saturated
module rad2_divider_seq #(
    parameter int X_W  = rad2_div_pkg::X_W,
    parameter int Y_W  = rad2_div_pkg::Y_W,
    parameter int FRAC = rad2_div_pkg::FRAC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] q,
    output logic           sat,
    output logic           dbz
);

    localparam int DVD_W = X_W + FRAC;
    localparam int REM_W = Y_W + 1;
    localparam int CNT_W = rad2_div_pkg::CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVD_W);
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
    localparam logic [X_W-1:0]   Q_MAX    = {1'b0, {(X_W-1){1'b1}}};
    localparam logic [X_W-1:0]   Q_MIN    = {1'b1, {(X_W-1){1'b0}}};

    rad2_div_pkg::state_t state, state_nxt;

    logic [DVD_W-1:0] dvd;
    logic [Y_W-1:0]   dvs;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;
    logic [CNT_W-1:0] cnt;
    logic             q_bit;
    logic             neg;
    logic             x_neg;
    logic             dvs_zero;
    logic [X_W-1:0]   q_r;
    logic             sat_r;
    logic             dbz_r;
    logic [X_W-1:0]   q_fix;
    logic             sat_fix;
    logic [X_W-1:0]   x_abs;
    logic [Y_W-1:0]   y_abs;

    assign x_abs = x[X_W-1] ? (~x + X_ONE) : x;
    assign y_abs = y[Y_W-1] ? (~y + Y_ONE) : y;

    rad2_div_step u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[DVD_W-1]),
        .dvs     (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= rad2_div_pkg::ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            rad2_div_pkg::ST_IDLE: if (in_valid)        state_nxt = rad2_div_pkg::ST_CALC;
            rad2_div_pkg::ST_CALC: if (cnt == LAST_CNT) state_nxt = rad2_div_pkg::ST_FIX;
            rad2_div_pkg::ST_FIX:                       state_nxt = rad2_div_pkg::ST_DONE;
            rad2_div_pkg::ST_DONE: if (out_ready)       state_nxt = rad2_div_pkg::ST_IDLE;
            default:                                    state_nxt = rad2_div_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == rad2_div_pkg::ST_IDLE);
        out_valid = (state == rad2_div_pkg::ST_DONE);
    end

    // Sign, truncation and saturation of the unsigned quotient magnitude held in dvd
    always_comb begin
        q_fix   = '0;
        sat_fix = 1'b0;
        if (dvs_zero) begin
            q_fix   = x_neg ? Q_MIN : Q_MAX;
            sat_fix = 1'b1;
        end else if (neg) begin
            if ((|dvd[DVD_W-1:X_W]) || (dvd[X_W-1] && (|dvd[X_W-2:0]))) begin
                q_fix   = Q_MIN;
                sat_fix = 1'b1;
            end else begin
                q_fix = ~dvd[X_W-1:0] + X_ONE;
            end
        end else begin
            if (|dvd[DVD_W-1:X_W-1]) begin
                q_fix   = Q_MAX;
                sat_fix = 1'b1;
            end else begin
                q_fix = dvd[X_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            x_neg    <= 1'b0;
            dvs_zero <= 1'b0;
            q_r      <= '0;
            sat_r    <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            case (state)
                rad2_div_pkg::ST_IDLE: begin
                    if (in_valid) begin
                        dvd      <= {x_abs, {FRAC{1'b0}}};
                        dvs      <= y_abs;
                        rem      <= '0;
                        cnt      <= '0;
                        neg      <= x[X_W-1] ^ y[Y_W-1];
                        x_neg    <= x[X_W-1];
                        dvs_zero <= (y == '0);
                    end
                end
                rad2_div_pkg::ST_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    // cnt==0 is the load slot, so the 42 steps run on cnt 1..42
                    if (cnt != '0) begin
                        rem <= rem_nxt;
                        dvd <= {dvd[DVD_W-2:0], q_bit};
                    end
                end
                rad2_div_pkg::ST_FIX: begin
                    q_r   <= q_fix;
                    sat_r <= sat_fix;
                    dbz_r <= dvs_zero;
                end
                rad2_div_pkg::ST_DONE: begin
                    if (out_ready) begin
                        q_r   <= '0;
                        sat_r <= 1'b0;
                        dbz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q   = q_r;
    assign sat = sat_r;
    assign dbz = dbz_r;

endmodule

// File: tb/tb_rad2_divider_seq.sv
// tb/tb_rad2_divider_seq.sv - directed self-checking bench for rad2_divider_seq
module tb_rad2_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [10:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic        sat;
    logic        dbz;

    int checks   = 0;
    int failures = 0;

    rad2_divider_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .sat       (sat),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] xv, input logic [10:0] yv,
                          input logic [31:0] eq, input logic es, input logic ed);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        x        = xv;
        y        = yv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x        = 32'hDEAD_BEEF;
        y        = 11'h155;
        check({tag, "_busy"}, {62'd0, in_ready, out_valid}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd44);
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_sat_dbz"}, {62'd0, sat, dbz}, {62'd0, es, ed});
        if (out_ready) begin
            tick();
            check({tag, "_release"}, {29'd0, in_ready, out_valid, sat, dbz, q}, {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        end
    endtask

    initial begin
        logic [31:0] q_hold;
        logic        bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        tick();
        tick();
        check("reset_state", {29'd0, in_ready, out_valid, sat, dbz, q}, {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        rst = 1'b0;
        tick();

        run_op("x1000_y512",  32'd1000,      11'd512,        32'h0000_07D0, 1'b0, 1'b0);
        run_op("xm7_y3",      -32'sd7,       11'd3,          32'hFFFF_F6AB, 1'b0, 1'b0);
        run_op("xmax_y1",     32'h7FFF_FFFF, 11'd1,          32'h7FFF_FFFF, 1'b1, 1'b0);
        run_op("xmin_ym1024", 32'h8000_0000, 11'h400,        32'h7FFF_FFFF, 1'b1, 1'b0);
        run_op("x2p30_ym512", 32'h4000_0000, -11'sd512,      32'h8000_0000, 1'b0, 1'b0);
        run_op("x2p30_y512",  32'h4000_0000, 11'd512,        32'h7FFF_FFFF, 1'b1, 1'b0);
        run_op("xm5_y0",      -32'sd5,       11'd0,          32'h8000_0000, 1'b1, 1'b1);
        run_op("x5_y0",       32'd5,         11'd0,          32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("xm1000_y512", -32'sd1000,    11'd512,        32'hFFFF_F830, 1'b0, 1'b0);
        run_op("x1_ym1024",   32'd1,         11'h400,        32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("x0_ym3",      32'd0,         -11'sd3,        32'h0000_0000, 1'b0, 1'b0);
        run_op("x3_y1023",    32'd3,         11'd1023,       32'h0000_0003, 1'b0, 1'b0);

        // Backpressure: result must hold and new operands must be ignored
        out_ready = 1'b0;
        run_op("bp", 32'd1000, 11'd512, 32'h0000_07D0, 1'b0, 1'b0);
        q_hold = q;
        bad    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            x        = 32'd77;
            y        = 11'd1;
            tick();
            if (q !== 32'h0000_07D0 || sat !== 1'b0 || dbz !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_hold", {63'd0, bad}, 64'd0);
        check("bp_q_still", 64'(q), 64'(q_hold));
        out_ready = 1'b1;
        tick();
        check("bp_release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        check("bp_no_stray", {63'd0, bad}, 64'd0);

        // Reset on the 20th CALC cycle aborts the operation
        x        = 32'd1000;
        y        = 11'd512;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {29'd0, in_ready, out_valid, sat, dbz, q}, {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("abort_no_result", {63'd0, bad}, 64'd0);
        run_op("after_abort", 32'd1000, 11'd512, 32'h0000_07D0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
